// File: rtl/circ_queue_fifo.sv
// Circular-buffer FIFO with {flag, value} pointers, so any depth >= 2 works.
// One-cycle latency, no fall-through; flush clears pointers but not storage.
module circ_queue_fifo #(
    parameter int ENTRIES    = 6,
    parameter int DATA_WIDTH = 32,
    parameter int PTR_WIDTH  = $clog2(ENTRIES),
    parameter int CNT_WIDTH  = $clog2(ENTRIES + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  enq_valid_i,
    output logic                  enq_ready_o,
    input  logic [DATA_WIDTH-1:0] enq_data_i,
    output logic                  deq_valid_o,
    input  logic                  deq_ready_i,
    output logic [DATA_WIDTH-1:0] deq_data_o,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam logic [PTR_WIDTH-1:0] LAST_VAL  = PTR_WIDTH'(ENTRIES - 1);
    localparam logic [CNT_WIDTH:0]   ENTRIES_W = (CNT_WIDTH + 1)'(ENTRIES);
    localparam int                   PAD       = CNT_WIDTH + 1 - PTR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [ENTRIES];
    logic                  r_enq_flag;
    logic                  r_deq_flag;
    logic [PTR_WIDTH-1:0]  r_enq_val;
    logic [PTR_WIDTH-1:0]  r_deq_val;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_enq_fire;
    logic                  w_deq_fire;
    logic [PTR_WIDTH-1:0]  w_enq_val_nxt;
    logic [PTR_WIDTH-1:0]  w_deq_val_nxt;
    logic                  w_enq_flag_nxt;
    logic                  w_deq_flag_nxt;
    logic [CNT_WIDTH:0]    w_enq_wide;
    logic [CNT_WIDTH:0]    w_deq_wide;
    logic [CNT_WIDTH:0]    w_count_wide;

    // Status depends only on pointer state, never on the opposite port's inputs.
    assign w_empty = (r_enq_flag == r_deq_flag) && (r_enq_val == r_deq_val);
    assign w_full  = (r_enq_flag != r_deq_flag) && (r_enq_val == r_deq_val);

    assign w_enq_fire = enq_valid_i && !w_full && !flush_i;
    assign w_deq_fire = deq_ready_i && !w_empty && !flush_i;

    assign w_enq_val_nxt  = (r_enq_val == LAST_VAL) ? '0 : r_enq_val + 1'b1;
    assign w_enq_flag_nxt = (r_enq_val == LAST_VAL) ? ~r_enq_flag : r_enq_flag;
    assign w_deq_val_nxt  = (r_deq_val == LAST_VAL) ? '0 : r_deq_val + 1'b1;
    assign w_deq_flag_nxt = (r_deq_val == LAST_VAL) ? ~r_deq_flag : r_deq_flag;

    assign w_enq_wide   = {{PAD{1'b0}}, r_enq_val};
    assign w_deq_wide   = {{PAD{1'b0}}, r_deq_val};
    assign w_count_wide = (r_enq_flag == r_deq_flag) ? (w_enq_wide - w_deq_wide)
                                                     : (ENTRIES_W + w_enq_wide - w_deq_wide);

    assign count_o     = w_count_wide[CNT_WIDTH-1:0];
    assign full_o      = w_full;
    assign empty_o     = w_empty;
    assign enq_ready_o = !w_full;
    assign deq_valid_o = !w_empty;
    assign deq_data_o  = r_mem[r_deq_val];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_enq_flag <= 1'b0;
            r_enq_val  <= '0;
            r_deq_flag <= 1'b0;
            r_deq_val  <= '0;
        end else if (flush_i) begin
            r_enq_flag <= 1'b0;
            r_enq_val  <= '0;
            r_deq_flag <= 1'b0;
            r_deq_val  <= '0;
        end else begin
            if (w_enq_fire) begin
                r_enq_flag <= w_enq_flag_nxt;
                r_enq_val  <= w_enq_val_nxt;
            end
            if (w_deq_fire) begin
                r_deq_flag <= w_deq_flag_nxt;
                r_deq_val  <= w_deq_val_nxt;
            end
        end
    end

    // Storage is deliberately left out of reset and flush.
    always_ff @(posedge clk_i) begin
        if (w_enq_fire) begin
            r_mem[r_enq_val] <= enq_data_i;
        end
    end

endmodule

// File: tb/tb_circ_queue_fifo.sv
// Directed bench for circ_queue_fifo: a 6-entry instance for fill/drain/flush/reset
// and a 5-entry instance for a continuous stream across many pointer wraps.
module tb_circ_queue_fifo;

    logic        clk;
    logic        rst;

    logic        flush6, enq_valid6, enq_ready6, deq_valid6, deq_ready6, full6, empty6;
    logic [31:0] enq_data6, deq_data6;
    logic [2:0]  count6;

    logic        flush5, enq_valid5, enq_ready5, deq_valid5, deq_ready5, full5, empty5;
    logic [31:0] enq_data5, deq_data5;
    logic [2:0]  count5;

    int n_checks;
    int n_pass;

    circ_queue_fifo #(.ENTRIES(6), .DATA_WIDTH(32)) u_dut6 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush6),
        .enq_valid_i(enq_valid6), .enq_ready_o(enq_ready6), .enq_data_i(enq_data6),
        .deq_valid_o(deq_valid6), .deq_ready_i(deq_ready6), .deq_data_o(deq_data6),
        .count_o(count6), .full_o(full6), .empty_o(empty6)
    );

    circ_queue_fifo #(.ENTRIES(5), .DATA_WIDTH(32)) u_dut5 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush5),
        .enq_valid_i(enq_valid5), .enq_ready_o(enq_ready5), .enq_data_i(enq_data5),
        .deq_valid_o(deq_valid5), .deq_ready_i(deq_ready5), .deq_data_o(deq_data5),
        .count_o(count5), .full_o(full5), .empty_o(empty5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle6();
        enq_valid6 = 1'b0;
        deq_ready6 = 1'b0;
        flush6     = 1'b0;
    endtask

    task automatic push6(input logic [31:0] d);
        enq_valid6 = 1'b1;
        enq_data6  = d;
        step();
        enq_valid6 = 1'b0;
    endtask

    task automatic pop6_check(input string tag, input logic [31:0] exp);
        check(tag, deq_data6, exp);
        deq_ready6 = 1'b1;
        step();
        deq_ready6 = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b0;
        flush6 = 1'b0; enq_valid6 = 1'b0; deq_ready6 = 1'b0; enq_data6 = '0;
        flush5 = 1'b0; enq_valid5 = 1'b0; deq_ready5 = 1'b0; enq_data5 = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_count", 32'(count6), 32'd0);
        check("rst_empty", 32'(empty6), 32'd1);
        check("rst_full", 32'(full6), 32'd0);
        check("rst_enq_ready", 32'(enq_ready6), 32'd1);
        check("rst_deq_valid", 32'(deq_valid6), 32'd0);
        step();
        step();
        rst = 1'b0;

        // Fill 0x1..0x6 back-to-back, then offer a 7th.
        for (int k = 1; k <= 6; k++) push6(32'(k));
        check("fill_full", 32'(full6), 32'd1);
        check("fill_count", 32'(count6), 32'd6);
        check("fill_enq_ready", 32'(enq_ready6), 32'd0);
        push6(32'h7);
        check("seventh_refused_count", 32'(count6), 32'd6);

        // Drain and check order.
        for (int k = 1; k <= 6; k++) pop6_check($sformatf("drain_%0d", k), 32'(k));
        check("drain_empty", 32'(empty6), 32'd1);
        check("drain_count", 32'(count6), 32'd0);

        // Full with enqueue and dequeue together: only the dequeue happens.
        for (int k = 1; k <= 6; k++) push6(32'h10 + 32'(k));
        check("refill_count", 32'(count6), 32'd6);
        check("full_both_head", deq_data6, 32'h11);
        enq_valid6 = 1'b1; enq_data6 = 32'h77; deq_ready6 = 1'b1;
        step();
        idle6();
        check("full_both_count", 32'(count6), 32'd5);
        check("full_both_full", 32'(full6), 32'd0);
        for (int k = 2; k <= 6; k++) pop6_check($sformatf("after_full_%0d", k), 32'h10 + 32'(k));
        check("after_full_empty", 32'(empty6), 32'd1);

        // Empty with enqueue and dequeue together: no fall-through.
        check("nofall_valid_before", 32'(deq_valid6), 32'd0);
        enq_valid6 = 1'b1; enq_data6 = 32'hA5; deq_ready6 = 1'b1;
        #2;
        check("nofall_valid_same_cycle", 32'(deq_valid6), 32'd0);
        step();
        idle6();
        check("nofall_count", 32'(count6), 32'd1);
        check("nofall_data", deq_data6, 32'hA5);

        // Flush with a concurrent enqueue while 3 entries are held.
        push6(32'hB1);
        push6(32'hB2);
        check("pre_flush_count", 32'(count6), 32'd3);
        flush6 = 1'b1; enq_valid6 = 1'b1; enq_data6 = 32'hDD;
        step();
        idle6();
        check("flush_count", 32'(count6), 32'd0);
        check("flush_empty", 32'(empty6), 32'd1);
        push6(32'hC1);
        check("post_flush_count", 32'(count6), 32'd1);
        pop6_check("post_flush_data", 32'hC1);
        check("post_flush_empty", 32'(empty6), 32'd1);

        // Asynchronous reset between edges with 4 entries held.
        for (int k = 0; k < 4; k++) push6(32'hF0 + 32'(k));
        check("pre_rst_count", 32'(count6), 32'd4);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(deq_valid6), 32'd0);
        check("async_rst_count", 32'(count6), 32'd0);
        check("async_rst_ready", 32'(enq_ready6), 32'd1);
        #1 rst = 1'b0;
        enq_valid6 = 1'b1; enq_data6 = 32'hE1;
        step();
        idle6();
        check("post_rst_count", 32'(count6), 32'd1);
        check("post_rst_data", deq_data6, 32'hE1);

        // ENTRIES=5 stream of 23 entries; flags expected from wrap counts.
        enq_valid5 = 1'b1; enq_data5 = 32'd1; deq_ready5 = 1'b0;
        step();
        for (int k = 2; k <= 23; k++) begin
            check($sformatf("stream_count_%0d", k), 32'(count5), 32'd1);
            check($sformatf("stream_head_%0d", k), deq_data5, 32'(k - 1));
            enq_data5  = 32'(k);
            deq_ready5 = 1'b1;
            step();
            check($sformatf("stream_enq_flag_%0d", k), 32'(u_dut5.r_enq_flag), 32'((k / 5) % 2));
            check($sformatf("stream_deq_flag_%0d", k), 32'(u_dut5.r_deq_flag), 32'(((k - 1) / 5) % 2));
        end
        enq_valid5 = 1'b0;
        check("stream_last_data", deq_data5, 32'd23);
        step();
        deq_ready5 = 1'b0;
        check("stream_end_empty", 32'(empty5), 32'd1);
        check("stream_end_count", 32'(count5), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/circ_queue_fifo.md
CIRC_QUEUE_FIFO -- requirements
Module: circ_queue_fifo

Interface
REQ-001: Parameter ENTRIES, default 6, SHALL be the queue depth in entries; any value >= 2 SHALL be legal, including non-power-of-2 values.
REQ-002: Parameter DATA_WIDTH, default 32, SHALL be the payload width in bits.
REQ-003: Parameter PTR_WIDTH, default $clog2(ENTRIES), SHALL be derived from ENTRIES and SHALL never be overridden.
REQ-004: Parameter CNT_WIDTH, default $clog2(ENTRIES+1), SHALL be derived from ENTRIES and SHALL never be overridden.
REQ-005: clk_i  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-006: rst_i  input  1  SHALL be the reset, asynchronous and active-high.
REQ-007: flush_i  input  1  SHALL be the synchronous clear of all queue contents.
REQ-008: enq_valid_i  input  1  SHALL indicate that the producer offers enq_data_i.
REQ-009: enq_ready_o  output  1  SHALL indicate that the queue can accept an entry.
REQ-010: enq_data_i  input  DATA_WIDTH  SHALL carry the enqueue payload.
REQ-011: deq_valid_o  output  1  SHALL indicate that deq_data_o holds the head entry.
REQ-012: deq_ready_i  input  1  SHALL indicate that the consumer takes the head entry.
REQ-013: deq_data_o  output  DATA_WIDTH  SHALL carry the head payload.
REQ-014: count_o  output  CNT_WIDTH  SHALL report the number of occupied entries.
REQ-015: full_o  output  1  SHALL be high when count_o equals ENTRIES.
REQ-016: empty_o  output  1  SHALL be high when count_o equals 0.

Function
REQ-017: The enqueue pointer and the dequeue pointer SHALL each be a {flag, value[PTR_WIDTH-1:0]} pair.
REQ-018: On increment, a pointer value equal to ENTRIES-1 SHALL wrap to 0 and toggle its flag; otherwise the value SHALL increase by 1 and the flag SHALL hold.
REQ-019: empty_o SHALL be high when the two flags are equal and the two values are equal.
REQ-020: full_o SHALL be high when the two flags differ and the two values are equal.
REQ-021: When the flags are equal, count_o SHALL be enq.value - deq.value.
REQ-022: When the flags differ, count_o SHALL be ENTRIES + enq.value - deq.value, computed at CNT_WIDTH+1 bits with no overflow.
REQ-023: enq_ready_o SHALL equal !full_o.
REQ-024: deq_valid_o SHALL equal !empty_o.
REQ-025: Neither ready nor valid SHALL depend combinationally on the opposite port.
REQ-026: An enqueue handshake occurs when enq_valid_i && enq_ready_o.
REQ-027: On an enqueue handshake, enq_data_i SHALL be written to storage[enq.value] and the enqueue pointer SHALL increment.
REQ-028: A dequeue handshake occurs when deq_valid_o && deq_ready_i; on it the dequeue pointer SHALL increment.
REQ-029: deq_data_o SHALL be a combinational read of storage[deq.value].
REQ-030: deq_data_o SHALL be don't-care while empty_o is high.
REQ-031: Latency SHALL be one cycle: data enqueued at edge N SHALL give deq_valid_o high after edge N.
REQ-032: There SHALL be no fall-through and no bypass while empty.
REQ-033: Simultaneous enqueue and dequeue handshakes SHALL leave count_o unchanged, and both pointers SHALL advance.
REQ-034: When the queue is full, enqueue SHALL be refused even if a dequeue occurs in the same cycle.
REQ-035: When the queue is empty, no dequeue SHALL occur even if an enqueue occurs in the same cycle.
REQ-036: flush_i SHALL have priority over both handshakes.
REQ-037: A cycle with flush_i high SHALL return both pointers to {0,0} at the next edge and SHALL discard any enqueue in that cycle.
REQ-038: Storage contents SHALL not be cleared by flush_i.
REQ-039: Dequeue SHALL return entries in exactly the order they were enqueued, across any number of pointer wraps.

Reset
REQ-040: While rst_i is high, both pointers SHALL be {0,0} asynchronously.
REQ-041: During reset, count_o SHALL be 0, empty_o 1, full_o 0, enq_ready_o 1 and deq_valid_o 0.
REQ-042: Storage SHALL not be reset, and deq_data_o SHALL be don't-care during reset.
REQ-043: Assertion of rst_i mid-operation SHALL discard all contents immediately, without waiting for a clock edge.
REQ-044: After rst_i deasserts, the first enqueue SHALL be accepted at the next rising edge.

Verification
REQ-045: Scenario: ENTRIES=6, enqueue 0x1..0x6 back-to-back -> after 6 edges full_o=1, count_o=6, enq_ready_o=0; a 7th offer is not accepted.
REQ-046: Scenario: ENTRIES=6, then dequeue all -> data order 0x1..0x6, and after the last dequeue empty_o=1, count_o=0.
REQ-047: Scenario: ENTRIES=5, stream 23 entries with enqueue and dequeue both always active after the first entry -> count_o stays 1, pointer flags toggle on each wrap, and output order matches input.
REQ-048: Scenario: full queue with enq_valid_i=1 and deq_ready_i=1 in the same cycle -> only the dequeue occurs, and count_o drops from 6 to 5.
REQ-049: Scenario: 3 entries held, flush_i=1 together with an enqueue handshake -> next cycle count_o=0, empty_o=1, and the flushed data is never output.
REQ-050: Scenario: rst_i pulsed asynchronously between edges while 4 entries are held -> deq_valid_o=0 and count_o=0 immediately, before the next edge.
